// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES round controller.
package aes_package;

    localparam int unsigned NR_128  = 10;
    localparam int unsigned NR_192  = 12;
    localparam int unsigned NR_256  = 14;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned KEY_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_FINAL  = 2'd2,
        ST_OUTPUT = 2'd3
    } aes_round_state_t;

    typedef enum logic [KEY_W-1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } aes_key_len_t;

    // Datapath strobe bundle driven by the controller each cycle.
    typedef struct packed {
        logic load;
        logic round_en;
        logic final_rnd;
        logic ks_step;
    } aes_dp_ctrl_t;

    // Key length is usable when it is 128/192, or 256 with AES-256 enabled.
    function automatic logic key_ok(input logic [KEY_W-1:0] k, input logic en256);
        case (aes_key_len_t'(k))
            KEY_128, KEY_192: key_ok = 1'b1;
            KEY_256:          key_ok = en256;
            default:          key_ok = 1'b0;
        endcase
    endfunction

    // Number of rounds for a key length.
    function automatic logic [ROUND_W-1:0] nr_of(input logic [KEY_W-1:0] k);
        case (aes_key_len_t'(k))
            KEY_192: nr_of = ROUND_W'(NR_192);
            KEY_256: nr_of = ROUND_W'(NR_256);
            default: nr_of = ROUND_W'(NR_128);
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake, key-schedule and datapath control bundle of the AES round controller.
interface aes_round_ctrl_if
    import aes_package::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic [KEY_W-1:0]   key_len_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic               abort_i;
    logic               ks_ready_i;
    logic               ks_step_o;
    logic               dp_load_o;
    logic               dp_round_en_o;
    logic               dp_final_o;
    logic [ROUND_W-1:0] round_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [CNT_W-1:0]   block_cnt_o;

    // Upstream/environment side.
    modport master (
        output key_len_i, in_valid_i, abort_i, ks_ready_i, out_ready_i,
        input  in_ready_o, ks_step_o, dp_load_o, dp_round_en_o, dp_final_o,
               round_o, out_valid_o, busy_o, done_o, err_o, block_cnt_o
    );

    // Controller side.
    modport slave (
        input  key_len_i, in_valid_i, abort_i, ks_ready_i, out_ready_i,
        output in_ready_o, ks_step_o, dp_load_o, dp_round_en_o, dp_final_o,
               round_o, out_valid_o, busy_o, done_o, err_o, block_cnt_o
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a block, steps Nr rounds against the key
// schedule, presents the ciphertext and counts completed blocks.
module aes_round_ctrl
    import aes_package::*;
#(
    parameter bit          AES256_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clear,
    aes_round_ctrl_if.slave  bus
);

    aes_round_state_t   r_state;
    aes_round_state_t   w_state_nxt;
    logic [ROUND_W-1:0] r_rnd;
    logic [ROUND_W-1:0] w_rnd_nxt;
    logic [ROUND_W-1:0] r_nr;
    logic [ROUND_W-1:0] w_nr_nxt;
    logic [ROUND_W-1:0] r_round;
    logic [ROUND_W-1:0] w_round_nxt;
    logic [CNT_W-1:0]   r_block_cnt;
    logic               r_err;
    logic               r_done;
    logic               r_busy;
    logic               r_out_valid;
    aes_dp_ctrl_t       w_dp;
    logic               w_key_ok;
    logic               w_in_ready;
    logic               w_key_bad;
    logic               w_out_fire;

    assign w_key_ok = key_ok(bus.key_len_i, AES256_EN);

    // State register; clear has priority over every other event.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_rnd   <= '0;
            r_nr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
            r_nr    <= w_nr_nxt;
        end
    end

    // Next-state, round counting and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        w_nr_nxt    = r_nr;
        w_dp        = '0;
        w_in_ready  = 1'b0;
        w_key_bad   = 1'b0;
        w_out_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = w_key_ok;
                w_key_bad  = bus.in_valid_i & ~w_key_ok;
                if (bus.in_valid_i && w_key_ok) begin
                    w_dp.load   = 1'b1;
                    w_nr_nxt    = nr_of(bus.key_len_i);
                    w_rnd_nxt   = ROUND_W'(1);
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (bus.abort_i) begin
                    w_rnd_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.ks_ready_i) begin
                    w_dp.round_en = 1'b1;
                    w_dp.ks_step  = 1'b1;
                    w_rnd_nxt     = r_rnd + ROUND_W'(1);
                    if (r_rnd == r_nr - ROUND_W'(1)) begin
                        w_state_nxt = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                if (bus.abort_i) begin
                    w_rnd_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.ks_ready_i) begin
                    w_dp.round_en  = 1'b1;
                    w_dp.final_rnd = 1'b1;
                    w_dp.ks_step   = 1'b1;
                    w_state_nxt    = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.abort_i) begin
                    w_rnd_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.out_ready_i) begin
                    w_out_fire  = 1'b1;
                    w_rnd_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_rnd_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A clearing cycle must not disturb the datapath or key schedule.
        if (clear) begin
            w_dp = '0;
        end
    end

    // Round index as seen after the next edge.
    always_comb begin
        w_round_nxt = '0;
        case (w_state_nxt)
            ST_ROUND:            w_round_nxt = w_rnd_nxt;
            ST_FINAL, ST_OUTPUT: w_round_nxt = w_nr_nxt;
            default:             w_round_nxt = '0;
        endcase
    end

    // Registered status outputs, completion pulse, block counter and sticky error.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_round     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_block_cnt <= '0;
        end else begin
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_OUTPUT);
            r_round     <= w_round_nxt;
            r_done      <= w_out_fire;
            if (w_key_bad) begin
                r_err <= 1'b1;
            end
            if (w_out_fire) begin
                r_block_cnt <= r_block_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready_o    = w_in_ready;
    assign bus.dp_load_o     = w_dp.load;
    assign bus.dp_round_en_o = w_dp.round_en;
    assign bus.dp_final_o    = w_dp.final_rnd;
    assign bus.ks_step_o     = w_dp.ks_step;
    assign bus.round_o       = r_round;
    assign bus.out_valid_o   = r_out_valid;
    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.err_o         = r_err;
    assign bus.block_cnt_o   = r_block_cnt;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: cycle-level reference model plus directed and random blocks.
module tb_aes_round_ctrl;
    import aes_package::*;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic clear;
    logic clear2;
    always #5 clk = ~clk;

    aes_round_ctrl_if #(.CNT_W(CW)) bus ();
    aes_round_ctrl_if #(.CNT_W(CW)) bus2 ();

    aes_round_ctrl #(.AES256_EN(1'b1), .CNT_W(CW)) dut  (.clk(clk), .clear(clear),  .bus(bus));
    aes_round_ctrl #(.AES256_EN(1'b0), .CNT_W(CW)) dut2 (.clk(clk), .clear(clear2), .bus(bus2));

    // stimulus for the next cycle
    logic [1:0] c_key;
    logic c_valid, c_abort, c_ks, c_or, c_clear;

    // reference model: a block is "busy" while it has consumed m_steps of m_nr round keys
    bit m_busy, m_err, m_done, chk_on;
    int m_nr, m_steps, m_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // per-block observations
    int s_load, s_rnd, s_fin, s_step, s_done, s_ov, s_cyc, s_hs, s_ovrise, s_lastround, s_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        s_load = 0; s_rnd = 0; s_fin = 0; s_step = 0; s_done = 0; s_ov = 0;
        s_cyc = 0; s_hs = 0; s_ovrise = -1; s_lastround = 0; s_bad = 0;
    endtask

    task automatic cycle();
        bit kv, comp, strobe;
        int e_round;
        @(negedge clk);
        clear            = c_clear;
        bus.key_len_i    = c_key;
        bus.in_valid_i   = c_valid;
        bus.abort_i      = c_abort;
        bus.ks_ready_i   = c_ks;
        bus.out_ready_i  = c_or;
        #1;
        kv      = (c_key != 2'd3);
        comp    = m_busy && (m_steps < m_nr);
        strobe  = comp && c_ks && !c_abort && !c_clear;
        e_round = !m_busy ? 0 : (comp ? m_steps + 1 : m_nr);
        if (chk_on) begin
            chk("in_ready",    32'(bus.in_ready_o),    32'(!m_busy && kv));
            chk("dp_load",     32'(bus.dp_load_o),     32'(!m_busy && kv && c_valid && !c_clear));
            chk("dp_round_en", 32'(bus.dp_round_en_o), 32'(strobe));
            chk("ks_step",     32'(bus.ks_step_o),     32'(strobe));
            chk("dp_final",    32'(bus.dp_final_o),    32'(strobe && (m_steps == m_nr - 1)));
            chk("round",       32'(bus.round_o),       32'(e_round));
            chk("out_valid",   32'(bus.out_valid_o),   32'(m_busy && (m_steps == m_nr)));
            chk("busy",        32'(bus.busy_o),        32'(m_busy));
            chk("done",        32'(bus.done_o),        32'(m_done));
            chk("err",         32'(bus.err_o),         32'(m_err));
            chk("block_cnt",   32'(bus.block_cnt_o),   32'(m_cnt));
        end
        if (bus.dp_load_o === 1'b1) begin s_load++; s_hs = s_cyc; end
        if (bus.dp_round_en_o === 1'b1 && bus.dp_final_o !== 1'b1) s_rnd++;
        if (bus.dp_final_o === 1'b1) s_fin++;
        if (bus.ks_step_o === 1'b1) s_step++;
        if (bus.done_o === 1'b1) s_done++;
        if (bus.out_valid_o === 1'b1) begin
            s_ov++;
            if (s_ovrise < 0) s_ovrise = s_cyc - s_hs;
        end
        if (bus.busy_o === 1'b1) s_lastround = int'(bus.round_o);
        if (!c_ks && (bus.ks_step_o === 1'b1 || bus.dp_round_en_o === 1'b1)) s_bad++;
        s_cyc++;
        // advance the model across the edge
        m_done = 1'b0;
        if (c_clear) begin
            m_busy = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else if (!m_busy) begin
            if (c_valid && kv) begin
                m_busy  = 1'b1;
                m_nr    = (c_key == 2'd0) ? 10 : (c_key == 2'd1) ? 12 : 14;
                m_steps = 0;
            end else if (c_valid) begin
                m_err = 1'b1;
            end
        end else if (c_abort) begin
            m_busy = 1'b0;
        end else if (m_steps < m_nr) begin
            if (c_ks) m_steps++;
        end else if (c_or) begin
            m_busy = 1'b0;
            m_cnt  = (m_cnt + 1) % 16;
            m_done = 1'b1;
        end
    endtask

    // ksmode: 0 always ready, 1 low every 2nd cycle, 2 random
    // ormode: 0 always ready, 1 hold low 20 output cycles, 2 random, 3 abort with out_ready
    // abort_rnd: >0 abort at that round, <0 sporadic random abort, 0 none
    task automatic run_block(input int key, input int ksmode, input int ormode, input int abort_rnd);
        int g, orlow;
        g = 0; orlow = 0;
        reset_stats();
        c_clear = 1'b0; c_key = 2'(key); c_valid = 1'b1; c_abort = 1'b0;
        c_ks = 1'($urandom); c_or = 1'($urandom);
        cycle();
        while (m_busy && g < 400) begin
            g++;
            c_key   = 2'($urandom_range(0, 3));
            c_valid = 1'($urandom);
            case (ksmode)
                0:       c_ks = 1'b1;
                1:       c_ks = (g % 2 == 0) ? 1'b0 : 1'b1;
                default: c_ks = 1'($urandom);
            endcase
            c_abort = 1'b0;
            if (abort_rnd > 0) c_abort = (m_steps < m_nr) && (m_steps + 1 == abort_rnd);
            else if (abort_rnd < 0) c_abort = ($urandom_range(0, 29) == 0);
            case (ormode)
                0: c_or = 1'b1;
                1: begin
                    if (m_steps == m_nr) begin c_or = (orlow >= 20); orlow++; end
                    else c_or = 1'($urandom);
                end
                3: begin
                    c_or = 1'b1;
                    if (m_steps == m_nr) c_abort = 1'b1;
                end
                default: c_or = 1'($urandom);
            endcase
            cycle();
        end
        if (g >= 400) begin
            n_cmp++; n_fail++;
            $error("FAIL block_timeout observed=%0d expected=<400", g);
        end
        c_valid = 1'b0; c_abort = 1'b0; c_key = 2'($urandom_range(0, 3));
        cycle();
    endtask

    initial begin
        int saved;
        int guard;
        m_busy = 0; m_err = 0; m_done = 0; m_nr = 0; m_steps = 0; m_cnt = 0; chk_on = 0;
        c_clear = 1'b1; c_key = 2'd0; c_valid = 1'b0; c_abort = 1'b0; c_ks = 1'b0; c_or = 1'b0;
        clear2 = 1'b1;
        bus2.key_len_i = 2'd0; bus2.in_valid_i = 1'b0; bus2.abort_i = 1'b0;
        bus2.ks_ready_i = 1'b0; bus2.out_ready_i = 1'b0;
        reset_stats();

        // reset, with handshakes and ks_ready offered during clear
        cycle();
        chk_on = 1;
        c_valid = 1'b1; c_ks = 1'b1; c_abort = 1'b1;
        cycle();
        c_clear = 1'b0; c_valid = 1'b0; c_ks = 1'b0; c_abort = 1'b0;
        cycle();

        // AES-128, everything ready
        run_block(0, 0, 0, 0);
        chk("t128_loads",  32'(s_load), 32'(1));
        chk("t128_rounds", 32'(s_rnd), 32'(9));
        chk("t128_final",  32'(s_fin), 32'(1));
        chk("t128_ovrise", 32'(s_ovrise), 32'(11));
        chk("t128_done",   32'(s_done), 32'(1));
        chk("t128_cnt",    32'(bus.block_cnt_o), 32'(1));

        // AES-256, key schedule stalls every other cycle
        run_block(2, 1, 0, 0);
        chk("t256_steps",     32'(s_step), 32'(14));
        chk("t256_lastround", 32'(s_lastround), 32'(14));
        chk("t256_stallstrb", 32'(s_bad), 32'(0));

        // reserved key length: rejected, sticky error until clear
        c_key = 2'd3; c_valid = 1'b1;
        cycle();
        c_valid = 1'b0;
        repeat (4) cycle();
        chk("rsvd_err", 32'(bus.err_o), 32'(1));
        run_block(0, 2, 2, 0);
        chk("rsvd_err_sticky", 32'(bus.err_o), 32'(1));
        c_clear = 1'b1;
        cycle();
        c_clear = 1'b0;
        cycle();
        chk("rsvd_err_cleared", 32'(bus.err_o), 32'(0));

        // AES-192 aborted at round 5, then a clean block
        saved = m_cnt;
        run_block(1, 0, 0, 5);
        chk("abort_done", 32'(s_done), 32'(0));
        chk("abort_cnt",  32'(bus.block_cnt_o), 32'(saved));
        run_block(1, 0, 0, 0);
        chk("after_abort_done", 32'(s_done), 32'(1));
        chk("after_abort_cnt",  32'(bus.block_cnt_o), 32'((saved + 1) % 16));

        // output back-pressure, then abort racing out_ready
        run_block(0, 0, 1, 0);
        chk("bp_ovcycles", 32'(s_ov), 32'(21));
        chk("bp_round",    32'(s_lastround), 32'(10));
        run_block(1, 0, 3, 0);
        chk("abort_wins_done", 32'(s_done), 32'(0));

        // clear in mid-block beats abort, handshake and ks_ready
        reset_stats();
        c_key = 2'd0; c_valid = 1'b1; c_ks = 1'b1;
        cycle();
        c_valid = 1'b0;
        repeat (3) cycle();
        c_clear = 1'b1; c_abort = 1'b1; c_valid = 1'b1;
        cycle();
        c_clear = 1'b0; c_abort = 1'b0; c_valid = 1'b0;
        cycle();
        chk("midclear_steps", 32'(s_step), 32'(3));

        // counter wrap
        guard = 0;
        while (m_cnt != 15 && guard < 40) begin
            guard++;
            run_block($urandom_range(0, 2), 2, 2, 0);
        end
        run_block(0, 0, 0, 0);
        chk("wrap_cnt",  32'(bus.block_cnt_o), 32'(0));
        chk("wrap_done", 32'(s_done), 32'(1));

        // random traffic
        repeat (30) run_block($urandom_range(0, 3), 2, 2, -1);

        // AES-256 disabled instance
        @(negedge clk);
        clear2 = 1'b0; bus2.key_len_i = 2'd2; bus2.in_valid_i = 1'b1;
        #1;
        chk("no256_in_ready", 32'(bus2.in_ready_o), 32'(0));
        chk("no256_load",     32'(bus2.dp_load_o),  32'(0));
        @(negedge clk);
        bus2.in_valid_i = 1'b0; bus2.key_len_i = 2'd1;
        #1;
        chk("no256_err",       32'(bus2.err_o),      32'(1));
        chk("no256_192_ready", 32'(bus2.in_ready_o), 32'(1));
        bus2.in_valid_i = 1'b1;
        #1;
        chk("no256_192_load",  32'(bus2.dp_load_o),  32'(1));
        @(negedge clk);
        bus2.in_valid_i = 1'b0;
        #1;
        chk("no256_busy",      32'(bus2.busy_o),     32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter AES256_EN, default 1, meaning key_len 2'd2 (AES-256) is accepted; when 0 it is rejected.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the completed-block counter.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port clear, input, 1, reset; reset is synchronous and active-high.
REQ-005 SHALL have port key_len_i, input, 2, key length: 0=128, 1=192, 2=256, 3=reserved.
REQ-006 SHALL have port in_valid_i, input, 1, a plaintext block is present at the datapath input.
REQ-007 SHALL have port in_ready_o, output, 1, the controller accepts a block.
REQ-008 SHALL have port abort_i, input, 1, synchronous abort of the block in flight.
REQ-009 SHALL have port ks_ready_i, input, 1, the key schedule holds the next round key.
REQ-010 SHALL have port ks_step_o, output, 1, advance the key schedule by one round key.
REQ-011 SHALL have port dp_load_o, output, 1, load the state register with plaintext XOR key0.
REQ-012 SHALL have port dp_round_en_o, output, 1, apply one round to the state register.
REQ-013 SHALL have port dp_final_o, output, 1, the current round is final (no MixColumns).
REQ-014 SHALL have port round_o, output, 4, current round index.
REQ-015 SHALL have port out_valid_o, output, 1, the ciphertext in the state register is valid.
REQ-016 SHALL have port out_ready_i, input, 1, downstream accepts the ciphertext.
REQ-017 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done_o, output, 1, one-cycle pulse when the output handshake completes.
REQ-019 SHALL have port err_o, output, 1, sticky flag for an invalid key_len at input.
REQ-020 SHALL have port block_cnt_o, output, CNT_W, count of completed blocks.

Function
REQ-021 SHALL implement states IDLE, ROUND, FINAL, OUTPUT; Nr=10/12/14 for key_len 0/1/2.
REQ-022 IDLE SHALL drive in_ready_o=1 only when key_len_i is valid.
REQ-023 An IDLE handshake (in_valid_i & in_ready_o) SHALL:
- assert dp_load_o combinationally in the same cycle;
- latch Nr from key_len_i;
- set the round counter to 1;
- go to ROUND.
REQ-024 ROUND SHALL assert dp_round_en_o and ks_step_o only while ks_ready_i=1 and increment the counter on those cycles; when ks_ready_i=0 it SHALL hold the counter and deassert both strobes.
REQ-025 ROUND SHALL go to FINAL on the ks_ready_i cycle where counter==Nr-1.
REQ-026 FINAL SHALL, when ks_ready_i=1, assert dp_round_en_o, dp_final_o and ks_step_o, then go to OUTPUT.
REQ-027 OUTPUT SHALL hold out_valid_o=1 until out_ready_i=1, then pulse done_o, increment block_cnt_o (wrapping from all-ones to 0) and return to IDLE.
REQ-028 With ks_ready_i held high, out_valid_o SHALL rise exactly Nr+1 cycles after the input handshake.
REQ-029 round_o SHALL read:
- 0 in IDLE;
- the counter value in ROUND;
- Nr in FINAL and OUTPUT.
REQ-030 Changes on key_len_i after acceptance SHALL be ignored until the next IDLE.
REQ-031 In IDLE, an invalid key_len_i (3, or 2 with AES256_EN=0) together with in_valid_i=1 SHALL set err_o; err_o SHALL clear only on clear.
REQ-032 abort_i in any non-IDLE state SHALL return the FSM to IDLE next cycle, with no done_o pulse and no counter increment.
REQ-033 When abort_i and out_ready_i are both high in OUTPUT, abort SHALL win.
REQ-034 All datapath strobes SHALL be 0 in IDLE except dp_load_o on a handshake.

Reset
REQ-035 With clear=1 the block SHALL, on the next edge:
- go to IDLE;
- zero the round counter, block_cnt_o and err_o;
- drive all outputs to 0 except in_ready_o, which follows REQ-022.
REQ-036 clear SHALL override abort_i, handshakes and ks_ready_i in the same cycle.

Structure
REQ-037 Enum aes_round_state_t, enum aes_key_len_t and localparams NR_128/NR_192/NR_256 SHALL reside in aes_package.
REQ-038 The block SHALL be a single module with no sub-modules.

Verification
REQ-039 AES-128, ks_ready_i=1, out_ready_i=1 -> one dp_load_o, 9 round strobes, 1 dp_final_o; out_valid_o at cycle 11; block_cnt_o=1.
REQ-040 AES-256, ks_ready_i low on every 2nd cycle -> exactly 14 ks_step_o pulses; round_o ends at 14; no strobe while ks_ready_i=0.
REQ-041 key_len_i=3 with in_valid_i=1 -> in_ready_o=0, err_o=1 persisting until clear.
REQ-042 abort_i at round 5 of AES-192 -> IDLE next cycle, no done_o, block_cnt_o unchanged; the next block completes normally.
REQ-043 out_ready_i held low for 20 cycles in OUTPUT -> out_valid_o stays 1 and round_o=Nr; a simultaneous abort_i+out_ready_i gives no done_o.
REQ-044 block_cnt_o preset to 0xFFFF via 65535 blocks (or CNT_W=4 with 15 blocks) -> the next done_o wraps it to 0.
